// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM receiver.
// Default counter width matches the 10-bit PWM generator on the other end of the link.
package pwm_pkg;
  localparam int PWM_CNT_W   = 10;
  localparam int PWM_TIMEOUT = 2 ** PWM_CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// Latency: 2 clk cycles; no backpressure.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic ff1_d, ff1_q;
  logic ff2_d, ff2_q;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;
endmodule

// File: rtl/pwm_decode.sv
// PWM receiver: measures high time and period of each full cycle and reports duty/period/stuck.
// Latency: pin to valid 3 clk cycles after the closing rise; no backpressure, valid is a strobe.
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_sig,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stuck
);
  localparam logic [CNT_W:0]   TMO     = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   TMO_M1  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);
  localparam logic [CNT_W+1:0] PER_MAX = {1'b0, {(CNT_W+1){1'b1}}};

  logic s, s_d_q, rise, fall;
  state_t state_q, state_d;
  logic [CNT_W:0]   hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic [CNT_W:0]   hi_inc, lo_inc, period_meas;
  logic [CNT_W+1:0] sum;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d, stuck_q, stuck_d;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (PWM_sig),
    .q     (s)
  );

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Counters stick at the timeout value so a stuck line yields exactly one strobe.
  assign hi_inc      = (hi_cnt_q == TMO) ? TMO : hi_cnt_q + ONE;
  assign lo_inc      = (lo_cnt_q == TMO) ? TMO : lo_cnt_q + ONE;
  assign sum         = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
  assign period_meas = (sum > PER_MAX) ? PER_MAX[CNT_W:0] : sum[CNT_W:0];

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = ONE;
          stuck_d  = 1'b0;
        end else if (!s) begin
          lo_cnt_d = lo_inc;
          if (lo_cnt_q == TMO_M1) begin
            duty_d   = '0;
            period_d = TMO;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          lo_cnt_d = ONE;
          stuck_d  = 1'b0;
        end else if (s) begin
          hi_cnt_d = hi_inc;
          if (hi_cnt_q == TMO_M1) begin
            duty_d   = '1;
            period_d = TMO;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
          end
        end
      end
      LOW: begin
        // A rise on the timeout cycle still closes a valid period.
        if (rise) begin
          duty_d   = hi_cnt_q[CNT_W-1:0] - {{(CNT_W-1){1'b0}}, 1'b1};
          period_d = period_meas;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          state_d  = HIGH;
          hi_cnt_d = ONE;
        end else begin
          lo_cnt_d = lo_inc;
          if (lo_cnt_q == TMO_M1) begin
            duty_d   = '0;
            period_d = TMO;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d_q    <= 1'b0;
      state_q  <= IDLE;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      s_d_q    <= s;
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;
endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: drives PWM periods, queues the expected report for each period.
module tb_pwm_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        PWM_sig;
  logic [9:0]  duty;
  logic [10:0] period;
  logic        valid;
  logic        stuck;

  typedef struct {
    logic [9:0]  duty;
    logic [10:0] period;
    logic        stuck;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  int   pend_h = 0, pend_l = 0;
  bit   have_pend = 0;
  int   v0;

  pwm_decode dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PWM_sig (PWM_sig),
    .duty    (duty),
    .period  (period),
    .valid   (valid),
    .stuck   (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      vcount++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_valid observed duty=%0d period=%0d expected no strobe", duty, period);
      end
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        chk("valid_duty", duty, e_mon.duty);
        chk("valid_period", period, e_mon.period);
        chk("valid_stuck", stuck, e_mon.stuck);
      end
    end
  end

  task automatic push_exp(input int d, input int p, input bit st);
    exp_t e;
    e.duty   = 10'(d);
    e.period = 11'(p);
    e.stuck  = st;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input int n);
    PWM_sig = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The period in flight is reported on the rise that opens the next one.
  task automatic push_pending();
    if (have_pend)
      push_exp(pend_h - 1, (pend_h + pend_l > 2047) ? 2047 : pend_h + pend_l, 1'b0);
    have_pend = 0;
  endtask

  task automatic pwm_period(input int h, input int l);
    push_pending();
    drive(1'b1, h);
    drive(1'b0, l);
    pend_h    = h;
    pend_l    = l;
    have_pend = 1;
  endtask

  task automatic close_stream();
    push_pending();
    drive(1'b1, 2);
    drive(1'b0, 6);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    PWM_sig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    have_pend = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    PWM_sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", duty, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck", stuck, 0);
    rst_n = 1'b1;

    // 50% duty
    for (int i = 0; i < 3; i++) pwm_period(512, 512);
    close_stream();
    do_reset();

    // duty 0: single-cycle highs, rise lands on the low-side timeout cycle
    for (int i = 0; i < 3; i++) pwm_period(1, 1023);
    close_stream();
    chk("duty0_no_stuck", stuck, 0);
    do_reset();

    // duty change mid-stream
    pwm_period(201, 823);
    pwm_period(201, 823);
    pwm_period(801, 223);
    pwm_period(801, 223);
    close_stream();
    do_reset();

    // boundaries: odd short period, 1-clock low, 1-clock high and low
    pwm_period(3, 5);
    pwm_period(1023, 1);
    pwm_period(1, 1);
    close_stream();
    chk("short_last_duty", duty, 0);
    chk("short_last_period", period, 2);
    do_reset();

    // constant high
    v0 = vcount;
    push_exp(1023, 1024, 1'b1);
    drive(1'b1, 1100);
    chk("sh_stuck", stuck, 1);
    chk("sh_duty", duty, 1023);
    chk("sh_period", period, 1024);
    chk("sh_one_valid", vcount - v0, 1);
    drive(1'b0, 10);
    chk("sh_fall_clears", stuck, 0);
    chk("sh_fall_no_valid", vcount - v0, 1);
    chk("sh_queue", exp_q.size(), 0);
    do_reset();

    // constant low after reset, then resume duty 100
    v0 = vcount;
    push_exp(0, 1024, 1'b1);
    drive(1'b0, 1000);
    chk("sl_early_stuck", stuck, 0);
    drive(1'b0, 100);
    chk("sl_stuck", stuck, 1);
    chk("sl_duty", duty, 0);
    chk("sl_period", period, 1024);
    chk("sl_one_valid", vcount - v0, 1);
    pwm_period(101, 923);
    chk("sl_rise_clears", stuck, 0);
    chk("sl_rise_no_valid", vcount - v0, 1);
    pwm_period(101, 923);
    close_stream();
    chk("resume_duty", duty, 100);

    // reset while high: partial period discarded
    do_reset();
    pwm_period(201, 823);
    pwm_period(201, 823);
    push_pending();
    drive(1'b1, 50);
    chk("pre_rst_duty", duty, 200);
    rst_n   = 1'b0;
    PWM_sig = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_stuck", stuck, 0);
    rst_n     = 1'b1;
    have_pend = 0;
    v0 = vcount;
    drive(1'b0, 20);
    pwm_period(801, 223);
    chk("after_rst_one_rise_no_valid", vcount - v0, 0);
    pwm_period(801, 223);
    close_stream();
    chk("after_rst_duty", duty, 800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
